hls_activity_monitor: RTL and testbench

Synthesizable activity/performance monitor for one HLS kernel and one pipelined loop inside it. It watches the kernel's ap_start/ap_ready/ap_done/ap_continue handshake and the loop FSM's pipeline signals. It exposes transaction counts, latencies, trip counts, stall cycles and maximum initiation interval to on-chip debug logic. Purely observational: it never drives the DUT.

---
 rtl/hls_activity_monitor_pkg.sv | 28 ++
 rtl/hls_activity_monitor_if.sv | 39 +++
 rtl/hls_activity_monitor_loop_event_tracker.sv | 111 +++++++++++
 rtl/hls_activity_monitor.sv | 108 ++++++++++
 tb/tb_hls_activity_monitor.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/hls_activity_monitor_pkg.sv
// rtl/hls_activity_monitor_pkg.sv - shared types and counter helper for the activity monitor (MONITOR_SATURATE_EN)
package hls_activity_monitor_pkg;

    localparam int CNT_W_DEFAULT = 32;
    localparam int CNT_MAX_W     = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        WAIT_CONT = 2'd2
    } kstate_t;

    typedef enum logic {
        L_IDLE   = 1'b0,
        L_ACTIVE = 1'b1
    } lstate_t;

    // ones is the all-ones value of the caller's counter width
    function automatic logic [CNT_MAX_W-1:0] cnt_inc(input logic [CNT_MAX_W-1:0] v,
                                                     input logic [CNT_MAX_W-1:0] ones);
`ifdef MONITOR_SATURATE_EN
        return (v == ones) ? v : v + CNT_MAX_W'(1);
`else
        return (v + CNT_MAX_W'(1)) & ones;
`endif
    endfunction

endpackage

// File: rtl/hls_activity_monitor_if.sv
// rtl/hls_activity_monitor_if.sv - observed kernel and loop-pipeline signals
interface hls_activity_monitor_if #(
    parameter int STATE_W = 1
);
    logic               ap_start;
    logic               ap_ready;
    logic               ap_done;
    logic               ap_continue;
    logic [STATE_W-1:0] cur_state;
    logic [STATE_W-1:0] iter_start_state;
    logic [STATE_W-1:0] iter_end_state;
    logic [STATE_W-1:0] quit_state;
    logic               iter_start_block;
    logic               iter_end_block;
    logic               quit_block;
    logic               iter_start_enable;
    logic               iter_end_enable;
    logic               quit_enable;
    logic               loop_start;
    logic               loop_done;
    logic               loop_continue;
    logic               quit_at_end;

    modport master (
        output ap_start, ap_ready, ap_done, ap_continue,
        output cur_state, iter_start_state, iter_end_state, quit_state,
        output iter_start_block, iter_end_block, quit_block,
        output iter_start_enable, iter_end_enable, quit_enable,
        output loop_start, loop_done, loop_continue, quit_at_end
    );

    modport slave (
        input ap_start, ap_ready, ap_done, ap_continue,
        input cur_state, iter_start_state, iter_end_state, quit_state,
        input iter_start_block, iter_end_block, quit_block,
        input iter_start_enable, iter_end_enable, quit_enable,
        input loop_start, loop_done, loop_continue, quit_at_end
    );
endinterface

// File: rtl/hls_activity_monitor_loop_event_tracker.sv
// rtl/hls_activity_monitor_loop_event_tracker.sv - loop event decode, loop FSM and loop statistics
module loop_event_tracker
    import hls_activity_monitor_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frozen,
    hls_activity_monitor_if.slave  mon,
    output logic                   loop_active,
    output logic [CNT_W-1:0]       loop_run_count,
    output logic [CNT_W-1:0]       loop_last_trip,
    output logic [CNT_W-1:0]       loop_inflight,
    output logic [CNT_W-1:0]       loop_stall_count,
    output logic [CNT_W-1:0]       loop_max_ii
);

    localparam logic [CNT_MAX_W-1:0] ONES = (CNT_MAX_W'(1) << CNT_W) - CNT_MAX_W'(1);

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return CNT_W'(cnt_inc(CNT_MAX_W'(v), ONES));
    endfunction

    lstate_t          state_q, state_d;
    logic             it_start, it_end, quit_ev, stall;
    logic             entry, in_run, counted_start, complete, quit_mark;
    logic             quitting_q, seen_q;
    logic [CNT_W-1:0] trip_q, ii_q, trip_base, trip_cnt, infl_base, infl_next;

    assign it_start = (mon.cur_state == mon.iter_start_state) & mon.iter_start_enable & ~mon.iter_start_block;
    assign it_end   = (mon.cur_state == mon.iter_end_state) & mon.iter_end_enable & ~mon.iter_end_block;
    assign quit_ev  = (mon.cur_state == mon.quit_state) & mon.quit_enable & ~mon.quit_block;
    assign stall    = (mon.cur_state == mon.iter_start_state) & mon.iter_start_enable & mon.iter_start_block;

    always_ff @(posedge clock) begin
        if (reset) state_q <= L_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            L_IDLE:   if (mon.loop_start) state_d = L_ACTIVE;
            L_ACTIVE: if (mon.loop_done && mon.loop_continue) state_d = L_IDLE;
            default:  state_d = L_IDLE;
        endcase
    end

    always_comb begin
        loop_active = (state_q == L_ACTIVE);
    end

    // Entry cycle starts from cleared per-run state, so a stale quit flag never blocks it
    always_comb begin
        entry         = (state_q == L_IDLE) && mon.loop_start;
        in_run        = entry || (state_q == L_ACTIVE);
        counted_start = it_start && in_run && (entry || !quitting_q);
        complete      = (state_q == L_ACTIVE) && mon.loop_done && mon.loop_continue;
        quit_mark     = quit_ev && !mon.quit_at_end;
        trip_base     = entry ? '0 : trip_q;
        trip_cnt      = counted_start ? inc(trip_base) : trip_base;
        infl_base     = entry ? '0 : loop_inflight;
        infl_next     = infl_base;
        if (counted_start && !it_end)
            infl_next = inc(infl_base);
        else if (!counted_start && it_end && infl_base != '0)
            infl_next = infl_base - CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            trip_q     <= '0;
            ii_q       <= '0;
            seen_q     <= 1'b0;
            quitting_q <= 1'b0;
        end else begin
            if (in_run) trip_q <= trip_cnt;
            if (entry) quitting_q <= quit_mark;
            else if (state_q == L_ACTIVE && quit_mark) quitting_q <= 1'b1;
            if (counted_start) begin
                ii_q   <= CNT_W'(1);
                seen_q <= 1'b1;
            end else begin
                ii_q <= inc(ii_q);
                if (entry) seen_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            loop_run_count   <= '0;
            loop_last_trip   <= '0;
            loop_inflight    <= '0;
            loop_stall_count <= '0;
            loop_max_ii      <= '0;
        end else if (!frozen) begin
            loop_inflight <= infl_next;
            if (complete) begin
                loop_run_count <= inc(loop_run_count);
                loop_last_trip <= trip_cnt;
            end
            if (state_q == L_ACTIVE && stall)
                loop_stall_count <= inc(loop_stall_count);
            if (counted_start && seen_q && !entry && ii_q > loop_max_ii)
                loop_max_ii <= ii_q;
        end
    end

endmodule

// File: rtl/hls_activity_monitor.sv
// rtl/hls_activity_monitor.sv - kernel handshake FSM, freeze control and loop tracker (MONITOR_SATURATE_EN)
module hls_activity_monitor
    import hls_activity_monitor_pkg::*;
#(
    parameter int STATE_W = 1,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    hls_activity_monitor_if.slave  mon,
    input  logic                   finish,
    output logic                   mod_busy,
    output logic [CNT_W-1:0]       mod_txn_count,
    output logic [CNT_W-1:0]       mod_last_latency,
    output logic                   loop_active,
    output logic [CNT_W-1:0]       loop_run_count,
    output logic [CNT_W-1:0]       loop_last_trip,
    output logic [CNT_W-1:0]       loop_inflight,
    output logic [CNT_W-1:0]       loop_stall_count,
    output logic [CNT_W-1:0]       loop_max_ii,
    output logic                   frozen
);

    localparam logic [CNT_MAX_W-1:0] ONES = (CNT_MAX_W'(1) << CNT_W) - CNT_MAX_W'(1);

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return CNT_W'(cnt_inc(CNT_MAX_W'(v), ONES));
    endfunction

    kstate_t          state_q, state_d;
    logic [CNT_W-1:0] lat_q, done_lat;
    logic             txn_done;
    logic [STATE_W-1:0] unused_state_w;

    assign unused_state_w = mon.cur_state;

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mon.ap_start) begin
                    if (mon.ap_done) state_d = mon.ap_continue ? IDLE : WAIT_CONT;
                    else             state_d = RUN;
                end
            end
            RUN:       if (mon.ap_done) state_d = mon.ap_continue ? IDLE : WAIT_CONT;
            WAIT_CONT: if (mon.ap_continue) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Latency reported on completion counts the completing cycle itself
    always_comb begin
        mod_busy = (state_q != IDLE);
        txn_done = 1'b0;
        done_lat = inc(lat_q);
        case (state_q)
            IDLE: begin
                txn_done = mon.ap_start && mon.ap_done && mon.ap_continue;
                done_lat = CNT_W'(1);
            end
            RUN:       txn_done = mon.ap_done && mon.ap_continue;
            WAIT_CONT: txn_done = mon.ap_continue;
            default:   txn_done = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lat_q            <= '0;
            mod_txn_count    <= '0;
            mod_last_latency <= '0;
            frozen           <= 1'b0;
        end else begin
            if (finish) frozen <= 1'b1;
            if (state_q == IDLE) begin
                if (mon.ap_start) lat_q <= CNT_W'(1);
            end else begin
                lat_q <= inc(lat_q);
            end
            if (txn_done && !frozen) begin
                mod_txn_count    <= inc(mod_txn_count);
                mod_last_latency <= done_lat;
            end
        end
    end

    loop_event_tracker #(
        .CNT_W (CNT_W)
    ) u_loop (
        .clock            (clock),
        .reset            (reset),
        .frozen           (frozen),
        .mon              (mon),
        .loop_active      (loop_active),
        .loop_run_count   (loop_run_count),
        .loop_last_trip   (loop_last_trip),
        .loop_inflight    (loop_inflight),
        .loop_stall_count (loop_stall_count),
        .loop_max_ii      (loop_max_ii)
    );

endmodule

// File: tb/tb_hls_activity_monitor.sv
// tb/tb_hls_activity_monitor.sv - directed self-checking bench for hls_activity_monitor
module tb_hls_activity_monitor;
    localparam int CW = 4;

    logic clock = 1'b0;
    logic reset;
    logic finish;
    logic mod_busy, loop_active, frozen;
    logic [CW-1:0] mod_txn_count, mod_last_latency, loop_run_count, loop_last_trip;
    logic [CW-1:0] loop_inflight, loop_stall_count, loop_max_ii;
    int n_chk = 0;
    int n_bad = 0;

    hls_activity_monitor_if #(.STATE_W(1)) mon_if ();

    hls_activity_monitor #(.STATE_W(1), .CNT_W(CW)) dut (
        .clock            (clock),
        .reset            (reset),
        .mon              (mon_if.slave),
        .finish           (finish),
        .mod_busy         (mod_busy),
        .mod_txn_count    (mod_txn_count),
        .mod_last_latency (mod_last_latency),
        .loop_active      (loop_active),
        .loop_run_count   (loop_run_count),
        .loop_last_trip   (loop_last_trip),
        .loop_inflight    (loop_inflight),
        .loop_stall_count (loop_stall_count),
        .loop_max_ii      (loop_max_ii),
        .frozen           (frozen)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic lp(input logic s, input logic b, input logic e, input logic q);
        mon_if.iter_start_enable = s;
        mon_if.iter_start_block  = b;
        mon_if.iter_end_enable   = e;
        mon_if.quit_enable       = q;
        tick();
        mon_if.iter_start_enable = 1'b0;
        mon_if.iter_start_block  = 1'b0;
        mon_if.iter_end_enable   = 1'b0;
        mon_if.quit_enable       = 1'b0;
    endtask

    task automatic lstart();
        mon_if.loop_start = 1'b1;
        tick();
        mon_if.loop_start = 1'b0;
    endtask

    task automatic ldone();
        mon_if.loop_done = 1'b1;
        mon_if.loop_continue = 1'b1;
        tick();
        mon_if.loop_done = 1'b0;
    endtask

    task automatic pulse_start();
        mon_if.ap_start = 1'b1;
        tick();
        mon_if.ap_start = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_sat_txn, exp_sat_lat;
`ifdef MONITOR_SATURATE_EN
        exp_sat_txn = 15;
        exp_sat_lat = 15;
`else
        exp_sat_txn = 4;
        exp_sat_lat = 4;
`endif
        reset = 1'b1;
        finish = 1'b0;
        mon_if.ap_start = 0; mon_if.ap_ready = 0; mon_if.ap_done = 0; mon_if.ap_continue = 1;
        mon_if.cur_state = 1; mon_if.iter_start_state = 1; mon_if.iter_end_state = 1; mon_if.quit_state = 1;
        mon_if.iter_start_block = 0; mon_if.iter_end_block = 0; mon_if.quit_block = 0;
        mon_if.iter_start_enable = 0; mon_if.iter_end_enable = 0; mon_if.quit_enable = 0;
        mon_if.loop_start = 0; mon_if.loop_done = 0; mon_if.loop_continue = 0; mon_if.quit_at_end = 1;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", mod_busy, 0);
        chk("rst_txn", mod_txn_count, 0);
        chk("rst_lat", mod_last_latency, 0);
        chk("rst_lactive", loop_active, 0);
        chk("rst_maxii", loop_max_ii, 0);
        chk("rst_frozen", frozen, 0);

        // kernel: start, done five cycles later
        pulse_start();
        chk("k1_busy", mod_busy, 1);
        repeat (4) tick();
        mon_if.ap_done = 1; tick(); mon_if.ap_done = 0;
        chk("k1_txn", mod_txn_count, 1);
        chk("k1_lat", mod_last_latency, 6);
        chk("k1_idle", mod_busy, 0);

        // back-pressure: continue low for three cycles
        pulse_start();
        repeat (4) tick();
        mon_if.ap_done = 1; mon_if.ap_continue = 0; tick(); mon_if.ap_done = 0;
        chk("k2_wait_busy", mod_busy, 1);
        repeat (2) tick();
        chk("k2_wait_txn", mod_txn_count, 1);
        mon_if.ap_continue = 1; tick();
        chk("k2_txn", mod_txn_count, 2);
        chk("k2_lat", mod_last_latency, 9);
        chk("k2_idle", mod_busy, 0);

        // one-cycle transaction
        mon_if.ap_start = 1; mon_if.ap_done = 1; tick(); mon_if.ap_start = 0; mon_if.ap_done = 0;
        chk("k3_txn", mod_txn_count, 3);
        chk("k3_lat", mod_last_latency, 1);
        chk("k3_busy", mod_busy, 0);

        // loop at II=1, eight iterations, ends ten cycles after starts
        lstart();
        chk("l1_active", loop_active, 1);
        for (int t = 0; t < 20; t++) begin
            lp(t < 8, 0, (t >= 10 && t < 18), 0);
            if (t == 7) chk("l1_inflight8", loop_inflight, 8);
        end
        chk("l1_inflight0", loop_inflight, 0);
        ldone();
        chk("l1_done_active", loop_active, 0);
        chk("l1_runs", loop_run_count, 1);
        chk("l1_trip", loop_last_trip, 8);
        chk("l1_maxii", loop_max_ii, 1);

        // stalls between iterations 2 and 3; a start in the wrong state is ignored
        lstart();
        mon_if.cur_state = 0; lp(1, 0, 0, 0); mon_if.cur_state = 1;
        lp(1, 0, 0, 0); lp(1, 0, 0, 0);
        lp(1, 1, 0, 0); lp(1, 1, 0, 0);
        lp(1, 0, 0, 0); lp(1, 0, 0, 0);
        repeat (4) lp(0, 0, 1, 0);
        ldone();
        chk("l2_stall", loop_stall_count, 2);
        chk("l2_maxii", loop_max_ii, 3);
        chk("l2_trip", loop_last_trip, 4);
        chk("l2_runs", loop_run_count, 2);
        chk("l2_inflight", loop_inflight, 0);

        // quit event ends counting; simultaneous start+end keeps inflight
        mon_if.quit_at_end = 0;
        lstart();
        lp(1, 0, 0, 0);
        repeat (4) lp(1, 0, 1, 0);
        chk("l3_inflight1", loop_inflight, 1);
        lp(0, 0, 0, 1);
        lp(1, 0, 0, 0);
        chk("l3_spurious", loop_inflight, 1);
        lp(0, 0, 1, 0);
        lp(0, 0, 1, 0);
        chk("l3_underflow", loop_inflight, 0);
        ldone();
        chk("l3_trip", loop_last_trip, 5);
        chk("l3_runs", loop_run_count, 3);
        chk("l3_maxii", loop_max_ii, 3);

        // start coincident with completion is counted; idle stalls/starts are not
        mon_if.quit_at_end = 1;
        lstart();
        lp(1, 0, 0, 0);
        mon_if.iter_start_enable = 1; ldone(); mon_if.iter_start_enable = 0;
        chk("l4_trip", loop_last_trip, 2);
        chk("l4_runs", loop_run_count, 4);
        lp(0, 0, 1, 0); lp(0, 0, 1, 0);
        lp(1, 1, 0, 0);
        lp(1, 0, 0, 0);
        chk("l4_idle_stall", loop_stall_count, 2);
        chk("l4_idle_inflight", loop_inflight, 0);

        // freeze holds statistics while state outputs keep tracking
        finish = 1; tick(); finish = 0;
        chk("f_frozen", frozen, 1);
        pulse_start();
        chk("f_busy", mod_busy, 1);
        mon_if.ap_done = 1; tick(); mon_if.ap_done = 0;
        chk("f_busy_idle", mod_busy, 0);
        chk("f_txn", mod_txn_count, 3);
        chk("f_lat", mod_last_latency, 1);
        lstart();
        chk("f_lactive", loop_active, 1);
        lp(1, 0, 0, 0);
        ldone();
        chk("f_lidle", loop_active, 0);
        chk("f_runs", loop_run_count, 4);
        chk("f_trip", loop_last_trip, 2);
        chk("f_inflight", loop_inflight, 0);
        chk("f_still", frozen, 1);

        // reset clears everything, including mid-transaction
        reset = 1; tick(); reset = 0;
        chk("r_frozen", frozen, 0);
        chk("r_txn", mod_txn_count, 0);
        chk("r_maxii", loop_max_ii, 0);
        chk("r_runs", loop_run_count, 0);
        pulse_start();
        chk("r_mid_busy", mod_busy, 1);
        reset = 1; tick(); reset = 0;
        chk("r_mid_idle", mod_busy, 0);

        // twenty one-cycle transactions overflow a 4-bit counter
        mon_if.ap_start = 1; mon_if.ap_done = 1;
        repeat (20) tick();
        mon_if.ap_start = 0; mon_if.ap_done = 0;
        chk("w_txn", mod_txn_count, exp_sat_txn);

        // 20-cycle transaction overflows the latency counter
        pulse_start();
        repeat (18) tick();
        mon_if.ap_done = 1; tick(); mon_if.ap_done = 0;
        chk("w_lat", mod_last_latency, exp_sat_lat);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
